// File: rtl/mac_sequencer.sv
// MAC datapath sequencer: command -> optional clear -> operand stream -> byte-serial result (LS first).
// Accept-to-in_ready 1 cycle (2 with clear), last pair to out_valid 2 cycles; ena=0 freezes all state.
module mac_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_clear,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mac_en,
  output logic              mac_clr,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  acc_in,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int NB    = ACC_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic             clr_q;
  logic [IDX_W-1:0] idx;

  // Handshake outputs are combinational so a transfer completes in the cycle it is offered.
  assign cmd_ready = (state == S_IDLE) && ena;
  assign in_ready  = (state == S_RUN) && ena;
  assign mac_en    = in_ready && in_valid;
  assign mac_clr   = (state == S_CLEAR) && clr_q && ena;
  assign mac_a     = (state == S_RUN) ? a_in : '0;
  assign mac_b     = (state == S_RUN) ? b_in : '0;
  assign out_valid = (state == S_OUT);
  assign out_byte  = out_valid ? acc_in[{idx, 3'b000} +: 8] : 8'h00;
  assign busy      = (state != S_IDLE);
  // A DONE cycle under ena=0 defers the pulse until the block is enabled again.
  assign done      = (state == S_DONE) && ena;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      len_q <= '0;
      clr_q <= 1'b0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            len_q <= cmd_len;
            clr_q <= cmd_clear;
            cnt   <= '0;
            state <= cmd_clear ? S_CLEAR : S_RUN;
          end
        end
        S_CLEAR: state <= S_RUN;
        S_RUN: begin
          if (in_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == len_q) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          idx   <= '0;
          state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            if (idx == IDX_W'(NB - 1)) state <= S_DONE;
            else                       idx   <= idx + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: attached accumulator plant, directed plan steps plus random runs,
// result bytes checked against sums of products computed per command.
module tb_mac_sequencer;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int LEN_W  = 4;
  localparam int NB     = ACC_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_clear;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              in_valid;
  logic              in_ready;
  logic              mac_en;
  logic              mac_clr;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic [ACC_W-1:0]  acc_in;
  logic [7:0]        out_byte;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  mac_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_clear(cmd_clear),
    .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .acc_in(acc_in), .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Accumulator plant, deliberately untouched by the sequencer reset.
  logic [ACC_W-1:0] dp_acc = '0;
  int en_cnt = 0, clr_cnt = 0, both_cnt = 0;
  assign acc_in = dp_acc;
  always @(posedge clk) begin
    if (mac_clr)     dp_acc <= '0;
    else if (mac_en) dp_acc <= dp_acc + ACC_W'(mac_a) * ACC_W'(mac_b);
    if (mac_en)             en_cnt   <= en_cnt + 1;
    if (mac_clr)            clr_cnt  <= clr_cnt + 1;
    if (mac_en && mac_clr)  both_cnt <= both_cnt + 1;
  end

  int n_chk = 0, n_fail = 0;
  logic [DATA_W-1:0] va [16];
  logic [DATA_W-1:0] vb [16];
  logic [ACC_W-1:0]  ref_acc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int n, input logic [7:0] a, input logic [7:0] b, input bit rnd);
    for (int i = 0; i < n; i++) begin
      va[i] = rnd ? 8'($urandom) : a;
      vb[i] = rnd ? 8'($urandom) : b;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
  // gap_mode: 0 back-to-back, 1 every other cycle, 2 random. out_wait<0 means random wait.
  task automatic do_run(input int n, input bit clr, input int gap_mode, input int out_wait,
                        input bit stall, input bit hold);
    logic [ACC_W-1:0] exp;
    int en0, clr0, k, cyc, w;
    bit rs_done;
    exp = clr ? '0 : ref_acc;
    for (int i = 0; i < n; i++) exp = exp + ACC_W'(va[i]) * ACC_W'(vb[i]);
    en0 = en_cnt; clr0 = clr_cnt; rs_done = 0;
    cmd_valid = 1'b1; cmd_len = LEN_W'(n - 1); cmd_clear = clr;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("busy_idle", busy, 0);
    @(negedge clk);
    cmd_valid = hold;
    #1;
    chk("cmd_ready_busy", cmd_ready, 0);
    chk("busy_after_accept", busy, 1);
    if (clr) begin
      chk("mac_clr_pulse", mac_clr, 1);
      chk("in_ready_clear", in_ready, 0);
      chk("mac_en_clear", mac_en, 0);
      @(negedge clk);
    end
    k = 0; cyc = 0;
    while (k < n && cyc < 200) begin
      if (stall && k == 1 && !rs_done) begin
        rs_done = 1;
        ena = 1'b0; in_valid = 1'b1; a_in = va[k]; b_in = vb[k];
        repeat (4) begin
          #1;
          chk("stall_run_mac_en", mac_en, 0);
          chk("stall_run_in_ready", in_ready, 0);
          chk("stall_run_busy", busy, 1);
          @(negedge clk);
        end
        ena = 1'b1;
      end
      case (gap_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom);
      endcase
      a_in = in_valid ? va[k] : 8'($urandom);
      b_in = in_valid ? vb[k] : 8'($urandom);
      #1;
      chk("run_mac_en", mac_en, in_valid);
      chk("run_in_ready", in_ready, 1);
      chk("run_cmd_ready", cmd_ready, 0);
      chk("run_mac_a", mac_a, a_in);
      chk("run_mac_b", mac_b, b_in);
      if (in_valid) k++;
      cyc++;
      @(negedge clk);
    end
    if (k < n) chk("run_timeout", k, n);
    in_valid = 1'b1; a_in = 8'hA5; b_in = 8'h5A;
    #1;
    chk("drain_out_valid", out_valid, 0);
    chk("drain_out_byte", out_byte, 0);
    chk("drain_mac_en", mac_en, 0);
    chk("drain_mac_a", mac_a, 0);
    chk("drain_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int bi = 0; bi < NB; bi++) begin
      w = (out_wait < 0) ? int'($urandom_range(0, 3)) : out_wait;
      repeat (w) begin
        out_ready = 1'b0;
        #1;
        chk("wait_out_valid", out_valid, 1);
        chk("wait_out_byte", out_byte, exp[8*bi +: 8]);
        chk("wait_done", done, 0);
        @(negedge clk);
      end
      if (stall && bi == 1) begin
        repeat (4) begin
          ena = 1'b0; out_ready = 1'b1;
          #1;
          chk("stall_out_valid", out_valid, 1);
          chk("stall_out_byte", out_byte, exp[8*bi +: 8]);
          chk("stall_out_done", done, 0);
          @(negedge clk);
        end
        ena = 1'b1;
      end
      out_ready = 1'b1;
      #1;
      chk("out_valid", out_valid, 1);
      chk("out_byte", out_byte, exp[8*bi +: 8]);
      chk("out_mac_en", mac_en, 0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    chk("done_pulse", done, 1);
    chk("done_out_valid", out_valid, 0);
    chk("done_cmd_ready", cmd_ready, 0);
    chk("done_busy", busy, 1);
    @(negedge clk);
    #1;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("mac_en_count", en_cnt - en0, n);
    chk("mac_clr_count", clr_cnt - clr0, clr);
    chk("strobe_overlap", both_cnt, 0);
    ref_acc = exp;
  endtask

  initial begin
    rst = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_clear = 1'b0;
    a_in = '0; b_in = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_byte", out_byte, 0);
    chk("reset_mac_en", mac_en, 0);
    chk("reset_mac_clr", mac_clr, 0);
    chk("reset_done", done, 0);
    chk("reset_in_ready", in_ready, 0);
    ena = 1'b0;
    #1;
    chk("ena_low_cmd_ready", cmd_ready, 0);
    ena = 1'b1;
    @(negedge clk);

    // Clear run of three pairs: 3*4+5*6+7*8 = 98.
    va[0] = 3; vb[0] = 4; va[1] = 5; vb[1] = 6; va[2] = 7; vb[2] = 8;
    do_run(3, 1'b1, 0, 0, 1'b0, 1'b0);
    chk("plan1_acc", dp_acc, 98);

    // Accumulate on top of 98: 98 + 65025 = 0x00FE63.
    va[0] = 255; vb[0] = 255;
    do_run(1, 1'b0, 0, 1, 1'b0, 1'b0);
    chk("plan2_acc", dp_acc, 24'h00FE63);

    // Sixteen 255*255 products under input gaps and output backpressure.
    fill(16, 8'd255, 8'd255, 1'b0);
    do_run(16, 1'b1, 1, 5, 1'b0, 1'b0);
    chk("plan3_acc", dp_acc, 24'h0FE010);

    // Reset after two of four pairs.
    fill(4, 8'd9, 8'd9, 1'b0);
    cmd_valid = 1'b1; cmd_len = 4'd3; cmd_clear = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) begin
      in_valid = 1'b1; a_in = 8'd9; b_in = 8'd9;
      @(negedge clk);
    end
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_mac_a", mac_a, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_done", done, 0);
    va[0] = 2; vb[0] = 3;
    do_run(1, 1'b1, 0, 0, 1'b0, 1'b0);
    chk("plan4_acc", dp_acc, 6);

    // Same vector unstalled and then stalled in RUN and OUT.
    fill(5, 8'd0, 8'd0, 1'b1);
    do_run(5, 1'b1, 0, 0, 1'b0, 1'b0);
    do_run(5, 1'b1, 0, 0, 1'b1, 1'b0);

    // cmd_valid held through a run: exactly one follow-on command is taken.
    fill(2, 8'd0, 8'd0, 1'b1);
    do_run(2, 1'b0, 0, 1, 1'b0, 1'b1);
    fill(3, 8'd0, 8'd0, 1'b1);
    do_run(3, 1'b1, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("hold_no_extra", busy, 0);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, 16));
      fill(n, 8'd0, 8'd0, 1'b1);
      do_run(n, 1'($urandom), 2, -1, (r == 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
